// File: rtl/pc_sequencer.sv
// Fetch-path program counter: sequential advance, jump, PC-relative branch and
// an optional hardware call/return stack enabled by the PC_CALL_STACK_EN macro.
module pc_sequencer #(
  parameter int               WIDTH        = 16,
  parameter int               OFF_WIDTH    = 8,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STACK_DEPTH  = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             STALL,
  input  logic                             JUMP,
  input  logic                             BRANCH,
  input  logic                             CALL,
  input  logic                             RET,
  input  logic [WIDTH-1:0]                 TARGET,
  input  logic [OFF_WIDTH-1:0]             OFFSET,
  output logic [WIDTH-1:0]                 PC_OUT,
  output logic [$clog2(STACK_DEPTH+1)-1:0] STACK_COUNT,
  output logic                             STACK_FULL,
  output logic                             STACK_EMPTY,
  output logic                             STACK_ERR
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  function automatic logic [WIDTH-1:0] sext_off(input logic signed [OFF_WIDTH-1:0] off);
    logic signed [WIDTH-1:0] ext;
    ext = WIDTH'(off);
    return ext;
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] pc_branch;

  assign pc_step   = pc_p0 + WIDTH'(STEP);
  assign pc_branch = pc_p0 + sext_off(OFFSET);
  assign PC_OUT    = pc_p0;

`ifdef PC_CALL_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0] cnt_p0;
  logic             err_p0;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             stack_full;
  logic             stack_empty;

  assign stack_full  = (cnt_p0 == CNT_W'(STACK_DEPTH));
  assign stack_empty = (cnt_p0 == '0);
  assign wr_idx      = IDX_W'(cnt_p0);
  assign rd_idx      = IDX_W'(cnt_p0 - 1'b1);

  assign STACK_COUNT = cnt_p0;
  assign STACK_FULL  = stack_full;
  assign STACK_EMPTY = stack_empty;
  assign STACK_ERR   = err_p0;

  // Stage p0: PC, stack pointer and sticky error update
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_p0  <= RESET_VECTOR;
      cnt_p0 <= '0;
      err_p0 <= 1'b0;
    end else if (!STALL) begin
      if (RET) begin
        if (!stack_empty) begin
          pc_p0  <= stack_mem[rd_idx];
          cnt_p0 <= cnt_p0 - 1'b1;
        end else begin
          pc_p0  <= pc_step;
          err_p0 <= 1'b1;
        end
      end else if (CALL) begin
        if (!stack_full) begin
          pc_p0  <= TARGET;
          cnt_p0 <= cnt_p0 + 1'b1;
        end else begin
          pc_p0  <= pc_step;
          err_p0 <= 1'b1;
        end
      end else if (JUMP) begin
        pc_p0 <= TARGET;
      end else if (BRANCH) begin
        pc_p0 <= pc_branch;
      end else begin
        pc_p0 <= pc_step;
      end
    end
  end

  // Return addresses carry no reset; only the count decides which are valid
  always_ff @(posedge CLK) begin
    if (!RST && !STALL && !RET && CALL && !stack_full) begin
      stack_mem[wr_idx] <= pc_step;
    end
  end
`else
  assign STACK_COUNT = '0;
  assign STACK_FULL  = 1'b0;
  assign STACK_EMPTY = 1'b1;
  assign STACK_ERR   = 1'b0;

  // Stage p0: without a stack, CALL is a plain jump and RET a plain advance
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_p0 <= RESET_VECTOR;
    end else if (!STALL) begin
      if (RET) begin
        pc_p0 <= pc_step;
      end else if (CALL || JUMP) begin
        pc_p0 <= TARGET;
      end else if (BRANCH) begin
        pc_p0 <= pc_branch;
      end else begin
        pc_p0 <= pc_step;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

  localparam int          WIDTH  = 16;
  localparam int          OFFW   = 8;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] RV     = 16'h0100;

  logic        CLK = 1'b0;
  logic        RST, STALL, JUMP, BRANCH, CALL, RET;
  logic [15:0] TARGET;
  logic [7:0]  OFFSET;
  logic [15:0] PC_OUT;
  logic [2:0]  STACK_COUNT;
  logic        STACK_FULL, STACK_EMPTY, STACK_ERR;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_err;

  pc_sequencer #(
    .WIDTH(WIDTH), .OFF_WIDTH(OFFW), .STEP(1), .RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH),
    .CALL(CALL), .RET(RET), .TARGET(TARGET), .OFFSET(OFFSET),
    .PC_OUT(PC_OUT), .STACK_COUNT(STACK_COUNT), .STACK_FULL(STACK_FULL),
    .STACK_EMPTY(STACK_EMPTY), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst, st, j, b, c, r, input logic [15:0] tgt,
                       input logic [7:0] off);
    if (rst) begin
      m_pc = RV;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!st) begin
      if (r) begin
`ifdef PC_CALL_STACK_EN
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
`else
        m_pc = m_pc + 16'd1;
`endif
      end else if (c) begin
`ifdef PC_CALL_STACK_EN
        if (m_stk.size() < DEPTH) begin m_stk.push_back(m_pc + 16'd1); m_pc = tgt; end
        else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
`else
        m_pc = tgt;
`endif
      end else if (j) m_pc = tgt;
      else if (b) m_pc = 16'(int'(m_pc) + int'($signed(off)));
      else m_pc = m_pc + 16'd1;
    end
  endtask

  // One clock: drive strobes, advance, update the model, compare everything.
  task automatic cyc(input string tag, input logic rst, st, j, b, c, r,
                     input logic [15:0] tgt, input logic [7:0] off);
    RST = rst; STALL = st; JUMP = j; BRANCH = b; CALL = c; RET = r;
    TARGET = tgt; OFFSET = off;
    @(posedge CLK);
    #1;
    model(rst, st, j, b, c, r, tgt, off);
    chk({tag, ".pc"}, PC_OUT, m_pc);
    chk({tag, ".cnt"}, 16'(STACK_COUNT), 16'(m_stk.size()));
    chk({tag, ".full"}, 16'(STACK_FULL), 16'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 16'(STACK_EMPTY), 16'(m_stk.size() == 0));
    chk({tag, ".err"}, 16'(STACK_ERR), 16'(m_err));
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
  endtask

  initial begin
    m_pc = '0;
    m_err = 1'b0;
    RST = 1'b1; STALL = 0; JUMP = 0; BRANCH = 0; CALL = 0; RET = 0;
    TARGET = '0; OFFSET = '0;

    // reset and advance
    cyc("reset", 1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    chk("reset.pc_const", PC_OUT, 16'h0100);
    idle("adv1");
    idle("adv2");
    idle("adv3");
    chk("adv3.pc_const", PC_OUT, 16'h0103);

    // wrap and branch
    cyc("jmp_ffff", 0, 0, 1, 0, 0, 0, 16'hFFFF, 8'h0);
    idle("wrap");
    chk("wrap.pc_const", PC_OUT, 16'h0000);
    cyc("br_neg", 0, 0, 0, 1, 0, 0, 16'h0, 8'hFC);
    chk("br_neg.pc_const", PC_OUT, 16'hFFFC);
    cyc("br_pos", 0, 0, 0, 1, 0, 0, 16'h0, 8'h10);
    chk("br_pos.pc_const", PC_OUT, 16'h000C);

    // priority and stall
    cyc("jmp_20", 0, 0, 1, 0, 0, 0, 16'h0020, 8'h0);
    cyc("stall_jmp", 0, 1, 1, 0, 0, 0, 16'h0500, 8'h0);
    chk("stall_jmp.pc_const", PC_OUT, 16'h0020);
    cyc("jmp_over_br", 0, 0, 1, 1, 0, 0, 16'h0500, 8'h7F);
    chk("jmp_over_br.pc_const", PC_OUT, 16'h0500);

    // nested calls
    cyc("jmp_10", 0, 0, 1, 0, 0, 0, 16'h0010, 8'h0);
    cyc("call1", 0, 0, 0, 0, 1, 0, 16'h0200, 8'h0);
    cyc("call2", 0, 0, 0, 0, 1, 0, 16'h0300, 8'h0);
    cyc("ret1", 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    cyc("ret2", 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);

    // overflow, LIFO unwind, stall holding the stack
    for (int i = 0; i < DEPTH + 1; i++)
      cyc($sformatf("ovf_call%0d", i), 0, 0, 0, 0, 1, 0, 16'h1000 + 16'(i * 16'h0100), 8'h0);
    cyc("stall_ret", 0, 1, 0, 0, 0, 1, 16'h0, 8'h0);
    for (int i = 0; i < DEPTH; i++)
      cyc($sformatf("unwind%0d", i), 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    idle("err_sticky");

    // underflow after reset, then reset clears the flag
    cyc("rst2", 1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    cyc("udf_ret", 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    idle("udf_sticky1");
    cyc("udf_sticky2", 0, 0, 1, 0, 0, 0, 16'h0AA0, 8'h0);

    // simultaneous strobes and reset discarding a call
    cyc("call_jmp", 0, 0, 1, 1, 1, 0, 16'h0700, 8'h05);
    cyc("ret_call", 0, 0, 0, 0, 1, 1, 16'h0800, 8'h0);
    cyc("call_b2b", 0, 0, 0, 0, 1, 0, 16'h0900, 8'h0);
    cyc("ret_b2b", 0, 0, 0, 0, 0, 1, 16'h0, 8'h0);
    cyc("call_pre", 0, 0, 0, 0, 1, 0, 16'h0A00, 8'h0);
    cyc("rst_call", 1, 0, 0, 0, 1, 0, 16'h0B00, 8'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rr, ss, jj, bb, cc, tt;
      rr = ($urandom_range(0, 39) == 0);
      ss = ($urandom_range(0, 7) == 0);
      jj = ($urandom_range(0, 5) == 0);
      bb = ($urandom_range(0, 3) == 0);
      cc = ($urandom_range(0, 3) == 0);
      tt = ($urandom_range(0, 3) == 0);
      cyc($sformatf("rnd%0d", i), rr, ss, jj, bb, cc, tt,
          16'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
